// File: rtl/shift_operand_stage.sv
// ARM32 operand-2 decode stage: normalises shift encodings, precomputes the
// shifter carry-out and presents the result through a 2-entry skid buffer.
module shift_operand_stage #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rm_val,
  input  logic [31:0]      rs_val,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      shift_in,
  output logic [1:0]       shift_op,
  output logic [31:0]      shift_amt,
  output logic             shift_carry,
  output logic             rrx_bit,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef struct packed {
    logic [31:0]      data;
    logic [1:0]       op;
    logic [5:0]       amt;
    logic             carry;
    logic             rrx;
    logic [TAG_W-1:0] tag;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t   state_q, state_d;
  payload_t or_q, or_d;
  payload_t sr_q, sr_d;
  logic     in_ready_q;

  payload_t    dec_s;
  logic [7:0]  a_s;
  logic [4:0]  lsl_idx_s;
  logic [4:0]  rgt_idx_s;
  logic [31:0] imm32_s;
  logic [5:0]  rot_amt_s;
  logic [31:0] rot_val_s;
  logic [1:0]  t_s;
  logic        accept_s;
  logic        drain_s;
  logic        unused_s;

  assign unused_s = ^{instr[31:26], instr[24:12], rs_val[31:8]};

  // Operand-2 decode into normalised shifter controls and carry-out
  always_comb begin
    dec_s     = '0;
    t_s       = instr[6:5];
    a_s       = instr[4] ? rs_val[7:0] : {3'd0, instr[11:7]};
    // LSL carries from bit 32-A; right shifts from bit A-1 (A=32 wraps to 31)
    lsl_idx_s = 5'd0 - a_s[4:0];
    rgt_idx_s = a_s[4:0] - 5'd1;
    imm32_s   = {24'd0, instr[7:0]};
    rot_amt_s = {1'b0, instr[11:8], 1'b0};
    rot_val_s = (imm32_s >> rot_amt_s) | (imm32_s << (6'd32 - rot_amt_s));
    dec_s.tag = in_tag;
    if (instr[25]) begin
      dec_s.data  = imm32_s;
      dec_s.op    = OP_ROR;
      dec_s.amt   = rot_amt_s;
      dec_s.carry = (instr[11:8] == 4'd0) ? carry_in : rot_val_s[31];
    end else begin
      dec_s.data = rm_val;
      dec_s.op   = t_s;
      if (a_s == 8'd0) begin
        if (instr[4] || (t_s == OP_LSL)) begin
          dec_s.amt   = 6'd0;
          dec_s.carry = carry_in;
        end else if (t_s == OP_ROR) begin
          // RRX: one-bit logical right shift with old C injected at bit 31
          dec_s.op    = OP_LSR;
          dec_s.amt   = 6'd1;
          dec_s.rrx   = carry_in;
          dec_s.carry = rm_val[0];
        end else begin
          dec_s.amt   = 6'd32;
          dec_s.carry = rm_val[31];
        end
      end else begin
        case (t_s)
          OP_LSL: begin
            dec_s.amt   = (a_s > 8'd32) ? 6'd32 : a_s[5:0];
            dec_s.carry = (a_s > 8'd32) ? 1'b0 : rm_val[lsl_idx_s];
          end
          OP_LSR: begin
            dec_s.amt   = (a_s > 8'd32) ? 6'd32 : a_s[5:0];
            dec_s.carry = (a_s > 8'd32) ? 1'b0 : rm_val[rgt_idx_s];
          end
          OP_ASR: begin
            dec_s.amt   = (a_s >= 8'd32) ? 6'd32 : a_s[5:0];
            dec_s.carry = (a_s >= 8'd32) ? rm_val[31] : rm_val[rgt_idx_s];
          end
          OP_ROR: begin
            dec_s.amt   = {1'b0, a_s[4:0]};
            dec_s.carry = (a_s[4:0] == 5'd0) ? rm_val[31] : rm_val[rgt_idx_s];
          end
          default: begin
            dec_s.amt   = 6'd0;
            dec_s.carry = carry_in;
          end
        endcase
      end
    end
  end

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept_s  = in_valid & in_ready_q;
  assign drain_s   = out_valid & out_ready;

  // Skid-buffer next state and register loads
  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sr_d    = sr_q;
    case (state_q)
      S_EMPTY: begin
        if (accept_s) begin
          or_d    = dec_s;
          state_d = S_ONE;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_ONE: begin
        if (accept_s && drain_s) begin
          or_d = dec_s;
        end else if (accept_s) begin
          sr_d    = dec_s;
          state_d = S_FULL;
        end else if (drain_s) begin
          state_d = S_EMPTY;
        end else begin
          state_d = S_ONE;
        end
      end
      S_FULL: begin
        if (drain_s) begin
          or_d    = sr_q;
          state_d = S_ONE;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    // Flush kills everything but leaves the last data on the outputs
    if (flush) begin
      state_d = S_EMPTY;
      or_d    = or_q;
      sr_d    = sr_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, ready flag and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      or_q       <= '0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);
      or_q       <= or_d;
      sr_q       <= sr_d;
    end
  end

  assign shift_in    = or_q.data;
  assign shift_op    = or_q.op;
  assign shift_amt   = {26'd0, or_q.amt};
  assign shift_carry = or_q.carry;
  assign rrx_bit     = or_q.rrx;
  assign out_tag     = or_q.tag;

endmodule
